// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo: PS/2 set-2 scancode to ASCII translator feeding a FWFT FIFO for MMIO readout.
// Ports: CLK/reset (async, active-high); code_valid/scan_code/upper scancode events from the
//        keyboard stage; rd_en pop strobe; clr_ovf clears overflow; rd_data FIFO head;
//        empty/full/count FIFO status; overflow sticky drop flag; intr = ~empty.
module ps2_ascii_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          code_valid,
  input  logic [7:0]    scan_code,
  input  logic          upper,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          intr
);
  logic          r_prev;
  logic          r_ext;
  logic          r_hit;
  logic [7:0]    r_char;
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          r_ovf;
  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    w_lo;
  logic [7:0]    w_sh;
  logic [7:0]    w_up;
  logic          w_event;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  // w_lo is the unshifted character (0 = unmapped); w_sh is the explicit shifted form for digits
  always_comb begin
    w_lo = 8'h00;
    w_sh = 8'h00;
    if (r_ext)
      case (scan_code)
        8'h75: w_lo = 8'h11;
        8'h72: w_lo = 8'h12;
        8'h6B: w_lo = 8'h13;
        8'h74: w_lo = 8'h14;
        8'h5A: w_lo = 8'h0D;
        8'h4A: w_lo = 8'h2F;
        default: w_lo = 8'h00;
      endcase
    else
      case (scan_code)
        8'h1C: w_lo = "a";
        8'h32: w_lo = "b";
        8'h21: w_lo = "c";
        8'h23: w_lo = "d";
        8'h24: w_lo = "e";
        8'h2B: w_lo = "f";
        8'h34: w_lo = "g";
        8'h33: w_lo = "h";
        8'h43: w_lo = "i";
        8'h3B: w_lo = "j";
        8'h42: w_lo = "k";
        8'h4B: w_lo = "l";
        8'h3A: w_lo = "m";
        8'h31: w_lo = "n";
        8'h44: w_lo = "o";
        8'h4D: w_lo = "p";
        8'h15: w_lo = "q";
        8'h2D: w_lo = "r";
        8'h1B: w_lo = "s";
        8'h2C: w_lo = "t";
        8'h3C: w_lo = "u";
        8'h2A: w_lo = "v";
        8'h1D: w_lo = "w";
        8'h22: w_lo = "x";
        8'h35: w_lo = "y";
        8'h1A: w_lo = "z";
        8'h16: {w_lo, w_sh} = {8'h31, 8'h21};
        8'h1E: {w_lo, w_sh} = {8'h32, 8'h40};
        8'h26: {w_lo, w_sh} = {8'h33, 8'h23};
        8'h25: {w_lo, w_sh} = {8'h34, 8'h24};
        8'h2E: {w_lo, w_sh} = {8'h35, 8'h25};
        8'h36: {w_lo, w_sh} = {8'h36, 8'h5E};
        8'h3D: {w_lo, w_sh} = {8'h37, 8'h26};
        8'h3E: {w_lo, w_sh} = {8'h38, 8'h2A};
        8'h46: {w_lo, w_sh} = {8'h39, 8'h28};
        8'h45: {w_lo, w_sh} = {8'h30, 8'h29};
        8'h29: w_lo = 8'h20;
        8'h5A: w_lo = 8'h0D;
        8'h66: w_lo = 8'h08;
        8'h0D: w_lo = 8'h09;
        8'h76: w_lo = 8'h1B;
        default: w_lo = 8'h00;
      endcase
  end
  // letters shift by case, digits use their symbol, everything else is case-independent
  assign w_up = (w_sh != 8'h00) ? w_sh : (w_lo >= "a" && w_lo <= "z") ? w_lo - 8'h20 : w_lo;
  assign w_event = code_valid & ~r_prev;
  assign count = r_wr - r_rd;
  assign empty = (count == '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign intr = ~empty;
  assign overflow = r_ovf;
  assign rd_data = empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  assign w_pop = rd_en & ~empty;
  // a pop in the same cycle frees the slot a full FIFO needs for the push
  assign w_wr = r_hit & (~full | w_pop);
  assign w_drop = r_hit & full & ~w_pop;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_ext <= 1'b0;
      r_hit <= 1'b0;
      r_char <= 8'h00;
      r_wr <= '0;
      r_rd <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_prev <= code_valid;
      r_hit <= 1'b0;
      if (w_event) begin
        if (scan_code == 8'hE0) r_ext <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_hit <= (w_lo != 8'h00);
          r_char <= upper ? w_up : w_lo;
        end
      end
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_ovf <= w_drop | (r_ovf & ~clr_ovf);
    end
  end
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr[AW-1:0]] <= r_char;
  end
endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// tb_ps2_ascii_fifo: scoreboard bench for the scancode-to-ASCII FIFO.
module tb_ps2_ascii_fifo;
  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       upper = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       intr;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];

  ps2_ascii_fifo #(.DEPTH(16)) dut (
    .CLK(CLK), .reset(reset), .code_valid(code_valid), .scan_code(scan_code),
    .upper(upper), .rd_en(rd_en), .clr_ovf(clr_ovf), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overflow(overflow), .intr(intr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] c, input logic u, input int hold = 1);
    @(negedge CLK);
    code_valid = 1'b1;
    scan_code = c;
    upper = u;
    repeat (hold) @(negedge CLK);
    code_valid = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_one(input string tag);
    int n = 0;
    logic [7:0] e;
    while (empty && n < 10) begin
      @(negedge CLK);
      n++;
    end
    e = exp_q.pop_front();
    if (empty) chk({tag, "_timeout"}, 16'(empty), 16'd0);
    else begin
      chk(tag, 16'(rd_data), 16'(e));
      rd_en = 1'b1;
      @(negedge CLK);
      rd_en = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one(tag);
    chk({tag, "_empty"}, 16'(empty), 16'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_empty"}, 16'(empty), 16'd1);
    chk({tag, "_full"}, 16'(full), 16'd0);
    chk({tag, "_count"}, 16'(count), 16'd0);
    chk({tag, "_ovf"}, 16'(overflow), 16'd0);
    chk({tag, "_intr"}, 16'(intr), 16'd0);
    chk({tag, "_data"}, 16'(rd_data), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check_reset_vals("rst_hold");
    reset = 1'b0;
    @(negedge CLK);
    check_reset_vals("rst");
    // 1: latency and single pop
    code_valid = 1'b1;
    scan_code = 8'h1C;
    upper = 1'b0;
    @(negedge CLK);
    code_valid = 1'b0;
    chk("lat_n1_empty", 16'(empty), 16'd1);
    @(negedge CLK);
    chk("lat_n2_empty", 16'(empty), 16'd0);
    chk("lat_count", 16'(count), 16'd1);
    chk("lat_intr", 16'(intr), 16'd1);
    chk("lat_data", 16'(rd_data), 16'h61);
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("pop1_empty", 16'(empty), 16'd1);
    chk("pop1_intr", 16'(intr), 16'd0);
    // 2: case handling
    send(8'h1C, 1'b1); exp_q.push_back(8'h41);
    send(8'h16, 1'b1); exp_q.push_back(8'h21);
    send(8'h16, 1'b0); exp_q.push_back(8'h31);
    send(8'h1E, 1'b1); exp_q.push_back(8'h40);
    send(8'h66, 1'b1); exp_q.push_back(8'h08);
    drain("case");
    // 3: held strobe, extended prefix
    send(8'h29, 1'b0, 9); exp_q.push_back(8'h20);
    repeat (2) @(negedge CLK);
    chk("hold_count", 16'(count), 16'd1);
    drain("hold");
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0); exp_q.push_back(8'h11);
    chk("ext_count", 16'(count), 16'd1);
    drain("ext");
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b0);
    repeat (2) @(negedge CLK);
    chk("ext_miss_count", 16'(count), 16'd0);
    send(8'h1C, 1'b0); exp_q.push_back(8'h61);
    send(8'hE0, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h4A, 1'b1); exp_q.push_back(8'h2F);
    drain("ext2");
    // 4: unmapped code, rd_en while empty
    send(8'h05, 1'b0);
    repeat (2) @(negedge CLK);
    chk("unmap_count", 16'(count), 16'd0);
    chk("unmap_ovf", 16'(overflow), 16'd0);
    rd_en = 1'b1;
    repeat (2) @(negedge CLK);
    rd_en = 1'b0;
    chk("rd_empty_count", 16'(count), 16'd0);
    send(8'h1C, 1'b0); exp_q.push_back(8'h61);
    chk("rd_empty_after", 16'(count), 16'd1);
    drain("rd_empty");
    // 5: overflow
    for (int i = 0; i < 17; i++) begin
      send(8'h1C, 1'b0);
      if (i < 16) exp_q.push_back(8'h61);
    end
    chk("ovf_full", 16'(full), 16'd1);
    chk("ovf_count", 16'(count), 16'd16);
    chk("ovf_flag", 16'(overflow), 16'd1);
    drain("ovf");
    chk("ovf_sticky", 16'(overflow), 16'd1);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'd0);
    // 6: push and pop together while full
    for (int i = 0; i < 16; i++) begin
      send(8'h1C, 1'b0);
      exp_q.push_back(8'h61);
    end
    chk("full6", 16'(full), 16'd1);
    @(negedge CLK);
    code_valid = 1'b1;
    scan_code = 8'h32;
    @(negedge CLK);
    code_valid = 1'b0;
    chk("simul_head", 16'(rd_data), 16'(exp_q.pop_front()));
    exp_q.push_back(8'h62);
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    chk("simul_count", 16'(count), 16'd16);
    chk("simul_ovf", 16'(overflow), 16'd0);
    drain("simul");
    // reset mid-stream discards queue and in-flight item
    for (int i = 0; i < 17; i++) send(8'h24, 1'b0);
    @(negedge CLK);
    code_valid = 1'b1;
    scan_code = 8'h1C;
    @(posedge CLK);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    code_valid = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("inflight_empty", 16'(empty), 16'd1);
    send(8'hE0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    send(8'h1C, 1'b0); exp_q.push_back(8'h61);
    drain("ext_rst");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
